// File: rtl/bcd_div4_sweep_pkg.sv
// Shared types, constants and BCD helpers for the divisible-by-4 sweep block.
package bcd_div4_pkg;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One BCD digit.
    typedef logic [3:0] digit_t;

    // Two-digit BCD value, tens in the upper nibble.
    typedef struct packed {
        digit_t tens;
        digit_t ones;
    } bcd2_t;

    localparam digit_t BCD_MAX = 4'd9;

    // Next BCD value. 99 is never incremented because the sweep stops at End.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones >= BCD_MAX) begin
            r.ones = 4'd0;
            r.tens = v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    // a <= b for two-digit BCD values: tens decide unless they are equal.
    function automatic logic bcd_le(input bcd2_t a, input bcd2_t b);
        if (a.tens != b.tens) begin
            return a.tens < b.tens;
        end
        return a.ones <= b.ones;
    endfunction

endpackage

// File: rtl/bcd_div4_sweep_if.sv
// Output stream of divisible values.
// Handshake: a value transfers on a rising edge where out_valid && out_ready;
// while out_valid is high and out_ready is low, out_t/out_o stay stable and
// out_valid stays high. out_valid never depends combinationally on out_ready.
interface bcd_div4_sweep_if;
    import bcd_div4_pkg::*;

    logic   out_valid;
    logic   out_ready;
    digit_t out_t;
    digit_t out_o;

    modport master (output out_valid, output out_t, output out_o, input out_ready);
    modport slave  (input out_valid, input out_t, input out_o, output out_ready);
endinterface

// File: rtl/bcd_div4_sweep_check.sv
// Combinational divisible-by-4 test on a two-digit BCD value.
module bcd_div4_check
    import bcd_div4_pkg::*;
(
    input  bcd2_t value,
    output logic  divisible
);

    logic [7:0] binary;

    // Convert to binary and test the low two bits; synthesis folds this to a
    // few gates since only tens parity and the ones digit matter.
    always_comb begin
        binary    = ({4'd0, value.tens} * 8'd10) + {4'd0, value.ones};
        divisible = ((binary % 8'd4) == 8'd0);
    end

endmodule

// File: rtl/bcd_div4_sweep.sv
// Walks an inclusive two-digit BCD range, streams each value divisible by 4
// over a valid/ready handshake, counts accepted hits and flags bad ranges.
module bcd_div4_sweep
    import bcd_div4_pkg::*;
#(
    parameter int COUNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  digit_t               start_t,
    input  digit_t               start_o,
    input  digit_t               end_t,
    input  digit_t               end_o,
    output logic                 busy,
    output logic [COUNT_W-1:0]   count,
    output logic                 done,
    output logic                 error,
    output state_t               state_dbg,
    bcd_div4_sweep_if.master     stream
);

    state_t               state;
    bcd2_t                cur;
    bcd2_t                last;
    logic                 busy_q;
    logic                 valid_q;
    digit_t               out_t_q;
    digit_t               out_o_q;
    logic [COUNT_W-1:0]   count_q;
    logic                 done_q;
    logic                 error_q;
    logic                 divisible;
    logic                 range_ok;
    bcd2_t                req_first;
    bcd2_t                req_last;

    bcd_div4_check u_check (
        .value     (cur),
        .divisible (divisible)
    );

    // Request decode: all digits legal and first value not above last value.
    always_comb begin
        req_first = '{tens: start_t, ones: start_o};
        req_last  = '{tens: end_t,   ones: end_o};
        range_ok  = (start_t <= BCD_MAX) && (start_o <= BCD_MAX) &&
                    (end_t   <= BCD_MAX) && (end_o   <= BCD_MAX) &&
                    bcd_le(req_first, req_last);
    end

    // Sweep FSM with all outputs registered on the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur     <= '0;
            last    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            out_t_q <= '0;
            out_o_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        last    <= req_last;
                        count_q <= '0;
                        if (range_ok) begin
                            error_q <= 1'b0;
                            cur     <= req_first;
                            busy_q  <= 1'b1;
                            state   <= CHECK;
                        end else begin
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                CHECK: begin
                    if (divisible) begin
                        valid_q <= 1'b1;
                        out_t_q <= cur.tens;
                        out_o_q <= cur.ones;
                        state   <= EMIT;
                    end else if (cur == last) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cur <= bcd_inc(cur);
                    end
                end
                EMIT: begin
                    if (stream.out_ready) begin
                        valid_q <= 1'b0;
                        count_q <= count_q + COUNT_W'(1);
                        if (cur == last) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cur   <= bcd_inc(cur);
                            state <= CHECK;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign count            = count_q;
    assign done             = done_q;
    assign error            = error_q;
    assign state_dbg        = state;
    assign stream.out_valid = valid_q;
    assign stream.out_t     = out_t_q;
    assign stream.out_o     = out_o_q;

endmodule

// File: tb/tb_bcd_div4_sweep.sv
// Self-checking bench for bcd_div4_sweep: directed boundary sweeps plus
// randomized ranges and backpressure against an arithmetic reference model.
module tb_bcd_div4_sweep;
    import bcd_div4_pkg::*;

    localparam int COUNT_W = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    digit_t             start_t = '0;
    digit_t             start_o = '0;
    digit_t             end_t = '0;
    digit_t             end_o = '0;
    logic               busy;
    logic [COUNT_W-1:0] count;
    logic               done;
    logic               error;
    state_t             state_dbg;

    bcd_div4_sweep_if sif ();

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    // Clock
    always #5 clk = ~clk;

    bcd_div4_sweep #(.COUNT_W(COUNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_t   (start_t),
        .start_o   (start_o),
        .end_t     (end_t),
        .end_o     (end_o),
        .busy      (busy),
        .count     (count),
        .done      (done),
        .error     (error),
        .state_dbg (state_dbg),
        .stream    (sif.master)
    );

    // Single comparison point.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit range_valid(input int st, input int so, input int et, input int eo);
        return (st <= 9) && (so <= 9) && (et <= 9) && (eo <= 9) &&
               ((st * 10 + so) <= (et * 10 + eo));
    endfunction

    function automatic int next_stall(input int fixed, input int max_stall);
        if (fixed >= 0) return fixed;
        return int'($urandom_range(0, max_stall));
    endfunction

    // One request, checked cycle by cycle until the Done pulse.
    // stall_fixed >= 0 forces that many refused cycles per emit; otherwise
    // each emit gets 0..stall_max refused cycles. poke_at > 0 pulses Start
    // in that cycle while the sweep is running.
    task automatic run_sweep(input int st, input int so, input int et, input int eo,
                             input int stall_fixed, input int stall_max, input int poke_at);
        bit valid;
        bit seen_done;
        int n_vals;
        int hits;
        int acc;
        int stalls;
        int stall_left;
        int cyc;
        valid = range_valid(st, so, et, eo);
        exp_q.delete();
        hits   = 0;
        n_vals = 0;
        if (valid) begin
            for (int v = st * 10 + so; v <= et * 10 + eo; v++) begin
                n_vals++;
                if (v % 4 == 0) begin
                    exp_q.push_back({4'(v / 10), 4'(v % 10)});
                    hits++;
                end
            end
        end
        stall_left = next_stall(stall_fixed, stall_max);
        acc = 0;
        stalls = 0;
        seen_done = 1'b0;

        @(negedge clk);
        start   = 1'b1;
        start_t = 4'(st);
        start_o = 4'(so);
        end_t   = 4'(et);
        end_o   = 4'(eo);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (!seen_done && cyc <= 400) begin
            if (cyc == 1) chk("error_cycle1", error, {31'd0, !valid});
            if (poke_at > 0 && cyc == poke_at) begin
                start = 1'b1;
                start_t = 4'd7; start_o = 4'd7; end_t = 4'd7; end_o = 4'd7;
            end else if (poke_at > 0 && cyc == poke_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                seen_done = 1'b1;
                chk("done_cycle", cyc, 1 + n_vals + hits + stalls);
                chk("count_final", count, hits);
                chk("error_final", error, {31'd0, !valid});
                chk("busy_at_done", busy, 0);
                chk("valid_at_done", sif.out_valid, 0);
                chk("emits_missing", exp_q.size(), 0);
            end else begin
                chk("busy_live", busy, 1);
                chk("count_live", count, acc);
                if (sif.out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_emit", sif.out_valid, 0);
                        sif.out_ready = 1'b1;
                    end else begin
                        chk("emit_value", {sif.out_t, sif.out_o}, exp_q[0]);
                        if (stall_left > 0) begin
                            sif.out_ready = 1'b0;
                            stall_left--;
                            stalls++;
                        end else begin
                            sif.out_ready = 1'b1;
                            void'(exp_q.pop_front());
                            acc++;
                            stall_left = next_stall(stall_fixed, stall_max);
                        end
                    end
                end else begin
                    sif.out_ready = 1'($urandom_range(0, 1));
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("done_seen", seen_done, 1);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", state_dbg, IDLE);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_state"}, state_dbg, IDLE);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, sif.out_valid, 0);
        chk({tag, "_out"}, {sif.out_t, sif.out_o}, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin
        int lo;
        int hi;
        sif.out_ready = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_zero_outputs("reset");

        // Full range, no backpressure, Start poked mid-sweep
        run_sweep(0, 0, 9, 9, 0, 0, 30);

        // Short ranges with and without a hit
        run_sweep(1, 3, 1, 5, 0, 0, 0);
        run_sweep(1, 3, 1, 6, 0, 0, 0);

        // Single value held under five cycles of backpressure
        run_sweep(0, 8, 0, 8, 5, 0, 0);

        // Illegal digit, reversed range, then a valid zero-only sweep
        run_sweep(1, 10, 2, 0, 0, 0, 0);
        run_sweep(5, 0, 2, 0, 0, 0, 0);
        run_sweep(0, 0, 0, 0, 0, 0, 0);

        // Random legal ranges with random backpressure
        for (int i = 0; i < 12; i++) begin
            lo = int'($urandom_range(0, 99));
            hi = int'($urandom_range(lo, (lo + 30 > 99) ? 99 : lo + 30));
            run_sweep(lo / 10, lo % 10, hi / 10, hi % 10, -1, 3, 0);
        end

        // Random raw digits, mostly illegal
        for (int i = 0; i < 4; i++) begin
            run_sweep(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), -1, 2, 0);
        end

        // Asynchronous reset in the middle of a sweep
        @(negedge clk);
        start = 1'b1;
        start_t = 4'd0; start_o = 4'd0; end_t = 4'd9; end_o = 4'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        sif.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(4, 0, 4, 4, -1, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_div4_sweep.md
# bcd_div4_sweep

Sequencer for the two-digit BCD divisible-by-4 checker. On a start request it walks every value in an inclusive BCD range, presents each value to the checker, and streams each divisible value out over a valid/ready handshake. It keeps a hit count and reports completion or a range error. It sits between a control/host stage and any consumer of divisible values, such as a display or logger.

## Interface
- COUNT_W, 5, width of hit counter; must be ≥5 (max 25 hits)
- Clock  in  1  rising-edge clock
- ResetN  in  1  asynchronous active-low reset
- Start  in  1  request sweep; sampled only in IDLE
- StartT, StartO  in  4 each  first value, tens/ones BCD digits
- EndT, EndO  in  4 each  last value (inclusive), tens/ones BCD digits
- Busy  out  1  high in CHECK and EMIT
- OutValid  out  1  divisible value available
- OutReady  in  1  consumer accepts value
- OutT, OutO  out  4 each  divisible value digits
- Count  out  COUNT_W  accepted hits in current/last sweep
- Done  out  1  one-cycle completion pulse
- Error  out  1  last request invalid; held until next accepted Start

## Operation
- Reset values are all zero: state IDLE, Busy=0, OutValid=0, OutT/OutO=0, Count=0, Done=0, Error=0, current value=00.
- **IDLE**
  - On Start=1, latch the range and clear Count and Error.
  - Validate the range: every digit ≤9 and Start value ≤ End value. Compare tens first, then ones.
  - Invalid range: Error←1, go to DONE.
  - Valid range: current←Start value, go to CHECK.
- **CHECK**
  - Drive the current value into the checker.
  - Divisible: go to EMIT.
  - Not divisible, current==End: go to DONE.
  - Not divisible, otherwise: BCD-increment current, stay in CHECK.
- **EMIT**
  - OutValid=1; OutT/OutO=current.
  - Hold OutT/OutO stable while OutReady=0.
  - On OutValid&&OutReady: Count+1. Then go to DONE if current==End, else BCD-increment current and go to CHECK.
- **DONE**
  - Done=1 for exactly one cycle, then go to IDLE.
  - Count and Error hold until the next accepted Start.
- BCD increment:
  - Ones 0–8: +1.
  - Ones 9: ones→0, tens+1.
  - 99 never increments, because End≤99 ends the sweep first.
- Start is ignored while in CHECK, EMIT or DONE.
- Boundary cases:
  - Start==End gives a single-value sweep.
  - Range 00..00 emits 00 (zero is divisible).
- ResetN low at any time, mid-sweep included: immediate return to the reset values. A pending OutValid is dropped without handshake.

## Timing
- Start sampled at edge 0; first CHECK in cycle 1.
- Each non-divisible value costs 1 cycle. Each divisible value costs 2 cycles (CHECK + EMIT) with OutReady held high, plus 1 cycle per cycle of backpressure.
- Done cycle = 1 + values in range + hits + stall cycles.
- Invalid request: Done and Error both high in cycle 1.
- OutValid is a registered state decode; no combinational path from OutReady to OutValid.
- OutT/OutO/Count are registered. The checker is combinational on the current register.
- Count updates on the edge where the handshake completes.

## Structure
- Shared package `bcd_div4_pkg` holds:
  - state enum: IDLE, CHECK, EMIT, DONE
  - BCD digit type (4 bits)
  - constant BCD_MAX=9
  - functions: BCD-increment and BCD less-or-equal compare
- One sub-module: `bcd_div4_check`, a combinational two-digit BCD divisible-by-4 check. It is instantiated once on the current-value register.
- Everything else (FSM, current-value register, counter, output registers) lives in the top.

## Test plan
- Full sweep 00..99, OutReady=1: emits 00,04,08,…,96 (25 values, in order); Count=25; Done at cycle 126; Busy low at cycle 126.
- Sweep 13..15: no OutValid, Count=0, Done at cycle 4. Sweep 13..16: single emit 16, Count=1, Done at cycle 6.
- Sweep 08..08 with OutReady=0 for 5 cycles: OutValid high with 08 stable for all 5 cycles; Count stays 0 until acceptance, then 1; Done the cycle after acceptance.
- Invalid requests: StartO=4'hA, or Start 50 with End 20. Each gives Error=1 and Done in cycle 1, with no OutValid. A following valid Start clears Error.
- Start pulsed while Busy during 00..99 is ignored. ResetN low mid-sweep: all outputs zero, asynchronously. After reset, a new Start 40..44 emits 40 and 44, Count=2.
